// File: rtl/divider_pkg.sv
// Shared types and defaults for the restoring divider.
// The optional feature is enabled with the DIVIDER_ZERO_DETECT_EN macro.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/divider_datapath.sv
// Shift-subtract datapath: partial remainder, quotient shift register and divisor hold.
// A load captures the operands and a shift performs one restoring iteration.
module divider_datapath
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quo,
    output logic [WIDTH-1:0] o_rem
);

    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;

    logic [WIDTH:0]   w_s;
    logic [WIDTH:0]   w_t;

    // Trial subtraction; a set MSB means the divisor did not fit, so restore.
    assign w_s = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_t = w_s - {1'b0, r_dvs};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
        end else if (i_load) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_dvs <= i_divisor;
        end else if (i_shift) begin
            if (!w_t[WIDTH]) begin
                r_rem <= w_t;
                r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end else begin
                r_rem <= w_s;
                r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign o_quo = r_quo;
    assign o_rem = r_rem[WIDTH-1:0];

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: control FSM, iteration counter and result registers.
// Define DIVIDER_ZERO_DETECT_EN to short-circuit division by zero and flag it on div_by_zero.
module restoring_divider
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_busy;
    logic             r_done;

    logic             w_load;
    logic             w_shift;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    assign w_load  = (r_state == IDLE) && i_start;
    assign w_shift = (r_state == RUN);

    divider_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .i_clk      (i_clock),
        .i_rst_n    (i_reset),
        .i_load     (w_load),
        .i_shift    (w_shift),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .o_quo      (w_quo),
        .o_rem      (w_rem)
    );

`ifdef DIVIDER_ZERO_DETECT_EN
    logic r_zero_skip;
    logic r_dbz;
`endif

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef DIVIDER_ZERO_DETECT_EN
            r_zero_skip <= 1'b0;
            r_dbz       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_cnt  <= CNT_W'(WIDTH);
                        r_busy <= 1'b1;
`ifdef DIVIDER_ZERO_DETECT_EN
                        r_dbz <= 1'b0;
                        if (i_divisor == '0) begin
                            r_zero_skip <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_zero_skip <= 1'b0;
                            r_state     <= RUN;
                        end
`else
                        r_state <= RUN;
`endif
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
`ifdef DIVIDER_ZERO_DETECT_EN
                    // Skipped run: the datapath still holds the untouched dividend in QUO.
                    if (r_zero_skip) begin
                        r_quotient  <= '1;
                        r_remainder <= w_quo;
                    end else begin
                        r_quotient  <= w_quo;
                        r_remainder <= w_rem;
                    end
                    r_dbz <= r_zero_skip;
`else
                    r_quotient  <= w_quo;
                    r_remainder <= w_rem;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_quotient  = r_quotient;
    assign o_remainder = r_remainder;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
`ifdef DIVIDER_ZERO_DETECT_EN
    assign o_div_by_zero = r_dbz;
`else
    assign o_div_by_zero = 1'b0;
`endif

endmodule
